uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter among four byte requesters. It sits between client logic and the UART TX datapath clocked by the UART clock generator. The block arbitrates requests and issues one start pulse per byte. It then tracks the transmitter's busy flag until the frame completes. Optional bounded bursts let one requester send several consecutive bytes without losing the grant.

## Interface
Parameters:
- MAX_BURST, 4: maximum bytes one requester may send per grant while holding lock (1..15).
- BUSY_TIMEOUT, 15: cycles after tx_start within which tx_busy must rise (1..255).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  4  per-requester byte request; bit i = requester i.
- lock  in  4  per-requester burst hold; meaningful only while that requester is granted.
- req_data  in  32  byte of requester i on bits [8i+7:8i].
- ack  out  4  one-hot, one-cycle pulse: byte of requester i taken.
- grant  out  4  one-hot owner of the transmitter; 0 when idle.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte presented to the transmitter; held until the next start.
- tx_busy  in  1  transmitter busy: high from frame start to stop-bit end.
- err  out  1  one-cycle pulse: tx_busy failed to rise within BUSY_TIMEOUT.

## Operation
- Requester contract:
  - Hold req[i] and its data stable until ack[i].
  - Each ack consumes exactly one byte.
  - After ack, deassert req or present the next byte.
- State machine: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - grant = 0.
  - If any req bit is high, pick the winner by rotating priority, starting at (last_owner+1) mod 4.
  - On that edge, register grant, tx_data = winner's byte, tx_start = 1, ack[winner] = 1, burst_cnt = 1. Go to START.
- START:
  - Lasts exactly one cycle; tx_start and ack are high only here.
  - Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy = 1: go to WAIT_DONE.
  - Timeout counter reaches BUSY_TIMEOUT first: pulse err, release grant, last_owner = owner, go to IDLE.
- WAIT_DONE, on tx_busy = 0:
  - If req[owner] & lock[owner] & (burst_cnt < MAX_BURST): register the new byte, tx_start = 1, ack[owner] = 1, burst_cnt + 1. Go to START with grant unchanged.
  - Otherwise: grant = 0, last_owner = owner, burst_cnt = 0. Go to IDLE.
- Priority rotates from the last owner after every release, including a timeout release. Starvation is bounded: a requester waits at most 3 grants of MAX_BURST bytes each.
- lock and req of non-owners are ignored while a grant is active.
- A req that drops before ack leaves no state behind.
- burst_cnt is 4 bits and never wraps, since it is capped by MAX_BURST.
- The timeout counter is 8 bits and saturates.

## Timing
- Reset values: grant = 0, ack = 0, tx_start = 0, tx_data = 8'h00, err = 0, state IDLE, last_owner = 3, so requester 0 has first priority.
- Reset mid-frame:
  - Returns to IDLE on the next edge and abandons the byte.
  - The transmitter is reset from the same rst_n.
- Latency:
  - req sampled high in IDLE at edge k: tx_start and ack are high in cycle k+1.
- Burst gap:
  - tx_busy sampled low at edge n: next tx_start in cycle n+1.
  - Release and re-arbitration takes one extra IDLE cycle.
- Simultaneous events:
  - req rising on the same edge the owner releases is not seen until IDLE.
  - tx_busy already high in START is ignored; it is sampled from WAIT_BUSY on.
- err pulses once per timeout, in the cycle after the counter hits BUSY_TIMEOUT.

## Test plan
- Single byte: reset, req = 0001, req_data[7:0] = 8'hA5, tx_busy high 3 cycles after start for 20 cycles.
  - Expect ack = 0001 and tx_start together, 1 cycle after req.
  - Expect tx_data = A5, then grant = 0 one cycle after tx_busy falls.
- Round-robin: req = 1111 held, lock = 0, each byte a distinct value.
  - Expect grant order 0, 1, 2, 3, 0, with one ack per byte and tx_data matching the owner.
- Burst: req = 0100 and lock = 0100 held, MAX_BURST = 4, req = 0001 also pending.
  - Expect exactly 4 consecutive tx_start pulses for requester 2, then requester 0 granted.
  - Expect a 1-cycle gap between tx_busy falling and each burst start.
- Timeout: req = 0010, tx_busy tied 0, BUSY_TIMEOUT = 15.
  - Expect err pulse 16 cycles after START, then grant = 0 and IDLE.
  - Next requester granted is 2 if pending.
- Reset mid-frame: assert rst_n = 0 for 1 cycle during WAIT_DONE.
  - Expect all outputs at reset values next edge.
  - Expect requester 0 to win the next arbitration with req = 1111.
- Request withdrawal: pulse req = 1000 for one cycle while another grant is active.
  - Expect no ack to requester 3 and no tx_start for its byte.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART TX among four byte requesters.
// Ports: req/lock/req_data from clients, ack/grant back; tx_start/tx_data/tx_busy to the TX; err on busy timeout.
module uart_tx_scheduler #(
  parameter int MAX_BURST    = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] last_owner;
  logic [3:0] burst_cnt;
  logic [7:0] tcnt;

  logic [1:0] winner;
  logic       found;
  logic [1:0] cand;
  logic [7:0] tcnt_nxt;
  logic       more;

  // Scan last_owner+1, +2, +3, +4 (mod 4); first requester wins.
  always_comb begin
    winner = last_owner;
    found  = 1'b0;
    cand   = last_owner;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign tcnt_nxt = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;

  // Owner keeps the grant only while it asks, holds lock and has budget left.
  assign more = req[owner] & lock[owner]
              & (burst_cnt < 4'(MAX_BURST));

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd3;
      burst_cnt  <= 4'd0;
      tcnt       <= 8'd0;
      grant      <= 4'd0;
      ack        <= 4'd0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      err        <= 1'b0;
    end else begin
      ack      <= 4'd0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner     <= winner;
            grant     <= 4'b0001 << winner;
            ack       <= 4'b0001 << winner;
            tx_data   <= req_data[{winner, 3'b000} +: 8];
            tx_start  <= 1'b1;
            burst_cnt <= 4'd1;
            state     <= START;
          end
        end
        START: begin
          tcnt  <= 8'd0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            tcnt <= tcnt_nxt;
            if (tcnt_nxt == 8'(BUSY_TIMEOUT)) begin
              err        <= 1'b1;
              grant      <= 4'd0;
              last_owner <= owner;
              burst_cnt  <= 4'd0;
              state      <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (more) begin
              tx_data   <= req_data[{owner, 3'b000} +: 8];
              tx_start  <= 1'b1;
              ack       <= grant;
              burst_cnt <= burst_cnt + 4'd1;
              state     <= START;
            end else begin
              grant      <= 4'd0;
              last_owner <= owner;
              burst_cnt  <= 4'd0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: self-checking bench for uart_tx_scheduler.
// Emulates the transmitter busy flag and compares against a queue-based arbitration model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int MAX_BURST    = 4;
  localparam int BUSY_TIMEOUT = 15;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int rise_in  = 0;
  int hold     = 0;
  int rise_dly = 2;
  int busy_len = 3;
  bit xmit_en  = 1'b1;
  int m_last   = 3;

  logic [7:0] q [4][$];

  typedef struct {
    int         who;
    logic [7:0] data;
    bit         cont;
  } exp_t;

  exp_t exp_q[$];

  always #5 sys_clk = ~sys_clk;

  uart_tx_scheduler #(
    .MAX_BURST(MAX_BURST),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .req(req),
    .lock(lock),
    .req_data(req_data),
    .ack(ack),
    .grant(grant),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .err(err)
  );

  task automatic apply_req();
    for (int i = 0; i < 4; i++) begin
      req[i] = (q[i].size() > 0);
      req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  function automatic int pending();
    int t;
    t = 0;
    for (int i = 0; i < 4; i++) t += q[i].size();
    return t;
  endfunction

  // One clock: sample after the edge, run the transmitter emulation,
  // retire acked bytes and present the next ones.
  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (!rst_n) begin
      tx_busy = 1'b0;
      rise_in = 0;
      hold    = 0;
    end else begin
      if (tx_busy) begin
        hold--;
        if (hold <= 0) begin
          tx_busy  = 1'b0;
          fall_cyc = cyc;
        end
      end else if (rise_in > 0) begin
        rise_in--;
        if (rise_in == 0) begin
          tx_busy = 1'b1;
          hold    = busy_len;
        end
      end
      if (xmit_en && tx_start) rise_in = rise_dly;
    end
    for (int i = 0; i < 4; i++)
      if (ack[i] && q[i].size() > 0) void'(q[i].pop_front());
    apply_req();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    req      = 4'd0;
    lock     = 4'd0;
    req_data = 32'd0;
    xmit_en  = 1'b1;
    step();
    step();
    rst_n  = 1'b1;
    m_last = 3;
  endtask

  // Expected byte order from the queues: rotating priority from the
  // previous owner, one byte per grant unless locked (then up to MAX_BURST).
  task automatic build_model(input logic [3:0] lk);
    logic [7:0] mq [4][$];
    int   last;
    int   w;
    int   n;
    int   c;
    bit   done;
    exp_t e;
    for (int i = 0; i < 4; i++) mq[i] = q[i];
    last = m_last;
    exp_q.delete();
    done = 1'b0;
    while (!done) begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (last + k) % 4;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w < 0) begin
        done = 1'b1;
      end else begin
        n = 0;
        do begin
          e.who  = w;
          e.data = mq[w].pop_front();
          e.cont = (n > 0);
          exp_q.push_back(e);
          n++;
        end while (lk[w] && n < MAX_BURST && mq[w].size() > 0);
        last = w;
      end
    end
    m_last = last;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 4'd0) begin
      failures++;
      $display("FAIL reset_grant: got %0h want 0", grant);
    end
    checks++;
    if (ack !== 4'd0) begin
      failures++;
      $display("FAIL reset_ack: got %0h want 0", ack);
    end
    checks++;
    if (tx_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_tx_start: got %0b want 0", tx_start);
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx_data: got %0h want 0", tx_data);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %0b want 0", err);
    end
  endtask

  task automatic test_single_byte();
    int n;
    do_reset();
    rise_dly = 3;
    busy_len = 20;
    q[0].push_back(8'hA5);
    apply_req();
    step();
    checks++;
    if (tx_start !== 1'b1 || ack !== 4'b0001) begin
      failures++;
      $display("FAIL single_start: got start=%0b ack=%0h want 1/1",
               tx_start, ack);
    end
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: got %0h want 1", grant);
    end
    checks++;
    if (tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_data: got %0h want a5", tx_data);
    end
    n = 0;
    while (grant != 4'd0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100 || cyc !== fall_cyc + 1) begin
      failures++;
      $display("FAIL single_release: got cyc %0d want %0d",
               cyc, fall_cyc + 1);
    end
    checks++;
    if (tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_hold: got %0h want a5", tx_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] lk;
    exp_t       e;
    int         budget;
    int         cnt;
    bit         first;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      if (r == 0) begin
        lk       = 4'b0000;
        rise_dly = 2;
        busy_len = 3;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 2; j++)
            q[i].push_back(8'(16 * (i + 1) + j));
      end else begin
        lk       = 4'($urandom_range(0, 15));
        rise_dly = $urandom_range(1, 4);
        busy_len = $urandom_range(1, 6);
        for (int i = 0; i < 4; i++) begin
          cnt = $urandom_range(0, 6);
          for (int j = 0; j < cnt; j++)
            q[i].push_back(8'($urandom_range(0, 255)));
        end
      end
      lock = lk;
      build_model(lk);
      apply_req();
      budget = 0;
      first  = 1'b1;
      while ((exp_q.size() != 0 || grant != 4'd0) && budget < 3000) begin
        step();
        budget++;
        if (|ack && !tx_start) begin
          checks++;
          failures++;
          $display("FAIL rr_ack_alone: got ack=%0h want 0", ack);
        end
        if (tx_start) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rr_extra: got grant=%0h want none", grant);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (grant !== 4'(1 << e.who) || ack !== 4'(1 << e.who)) begin
              failures++;
              $display("FAIL rr_owner r%0d: got g=%0h a=%0h want %0h",
                       r, grant, ack, 4'(1 << e.who));
            end
            checks++;
            if (tx_data !== e.data) begin
              failures++;
              $display("FAIL rr_data r%0d: got %0h want %0h",
                       r, tx_data, e.data);
            end
            if (!first) begin
              checks++;
              if (cyc !== fall_cyc + (e.cont ? 1 : 2)) begin
                failures++;
                $display("FAIL rr_gap r%0d: got %0d want %0d",
                         r, cyc - fall_cyc, e.cont ? 1 : 2);
              end
            end
            first = 1'b0;
          end
        end
      end
      checks++;
      if (budget >= 3000 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL rr_drain r%0d: got %0d left want 0",
                 r, exp_q.size());
      end
    end
    lock = 4'd0;
  endtask

  task automatic test_burst();
    logic [3:0] eg [7];
    logic [7:0] ed [7];
    int         egap [7];
    int         n;
    int         k;
    do_reset();
    rise_dly = 2;
    busy_len = 3;
    q[1].push_back(8'h11);
    apply_req();
    n = 0;
    while (grant == 4'd0 && n < 20) begin
      step();
      n++;
    end
    while (grant != 4'd0 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL burst_prefix: got timeout want release");
    end
    eg   = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
             4'b0001, 4'b0100, 4'b0100};
    ed   = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h0F, 8'h24, 8'h25};
    egap = '{0, 1, 1, 1, 2, 2, 1};
    lock = 4'b0100;
    for (int j = 0; j < 6; j++) q[2].push_back(8'(8'h20 + j));
    q[0].push_back(8'h0F);
    apply_req();
    k = 0;
    n = 0;
    while (k < 7 && n < 300) begin
      step();
      n++;
      if (tx_start) begin
        checks++;
        if (grant !== eg[k]) begin
          failures++;
          $display("FAIL burst_grant %0d: got %0h want %0h",
                   k, grant, eg[k]);
        end
        checks++;
        if (tx_data !== ed[k]) begin
          failures++;
          $display("FAIL burst_data %0d: got %0h want %0h",
                   k, tx_data, ed[k]);
        end
        if (k > 0) begin
          checks++;
          if (cyc !== fall_cyc + egap[k]) begin
            failures++;
            $display("FAIL burst_gap %0d: got %0d want %0d",
                     k, cyc - fall_cyc, egap[k]);
          end
        end
        k++;
      end
    end
    checks++;
    if (k != 7) begin
      failures++;
      $display("FAIL burst_count: got %0d want 7", k);
    end
    while (grant != 4'd0 && n < 400) begin
      step();
      n++;
    end
    lock = 4'd0;
  endtask

  task automatic test_timeout();
    int n;
    int s;
    do_reset();
    xmit_en = 1'b0;
    q[1].push_back(8'h5A);
    q[2].push_back(8'hC3);
    apply_req();
    n = 0;
    while (!tx_start && n < 10) begin
      step();
      n++;
    end
    s = cyc;
    checks++;
    if (grant !== 4'b0010 || tx_data !== 8'h5A) begin
      failures++;
      $display("FAIL to_first: got g=%0h d=%0h want 2/5a",
               grant, tx_data);
    end
    n = 0;
    while (!err && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (cyc !== s + BUSY_TIMEOUT + 1) begin
      failures++;
      $display("FAIL to_err_cycle: got %0d want %0d",
               cyc - s, BUSY_TIMEOUT + 1);
    end
    checks++;
    if (grant !== 4'd0) begin
      failures++;
      $display("FAIL to_release: got %0h want 0", grant);
    end
    xmit_en  = 1'b1;
    rise_dly = 2;
    busy_len = 3;
    step();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL to_err_pulse: got %0b want 0", err);
    end
    checks++;
    if (tx_start !== 1'b1 || grant !== 4'b0100 || tx_data !== 8'hC3) begin
      failures++;
      $display("FAIL to_next: got s=%0b g=%0h d=%0h want 1/4/c3",
               tx_start, grant, tx_data);
    end
    n = 0;
    while (grant != 4'd0 && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    rise_dly = 1;
    busy_len = 10;
    q[2].push_back(8'h77);
    apply_req();
    n = 0;
    while (!tx_busy && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    checks++;
    if (grant !== 4'b0100 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL rmf_setup: got g=%0h b=%0b want 4/1", grant, tx_busy);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    apply_req();
    step();
    checks++;
    if (grant !== 4'd0 || ack !== 4'd0 || tx_start !== 1'b0 ||
        tx_data !== 8'h00 || err !== 1'b0) begin
      failures++;
      $display("FAIL rmf_outputs: got g=%0h a=%0h s=%0b d=%0h e=%0b want 0",
               grant, ack, tx_start, tx_data, err);
    end
    rst_n    = 1'b1;
    rise_dly = 2;
    busy_len = 3;
    for (int i = 0; i < 4; i++) q[i].push_back(8'(8'hE0 + i));
    apply_req();
    n = 0;
    while (!tx_start && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (grant !== 4'b0001 || tx_data !== 8'hE0) begin
      failures++;
      $display("FAIL rmf_first: got g=%0h d=%0h want 1/e0", grant, tx_data);
    end
    n = 0;
    while ((grant != 4'd0 || pending() != 0) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL rmf_drain: got %0d left want 0", pending());
    end
  endtask

  task automatic test_withdrawal();
    int n;
    int starts;
    int a3;
    rise_dly = 2;
    busy_len = 6;
    starts   = 0;
    a3       = 0;
    q[0].push_back(8'h42);
    apply_req();
    n = 0;
    while (!tx_busy && n < 20) begin
      step();
      n++;
      if (tx_start) starts++;
      if (ack[3]) a3++;
    end
    step();
    if (tx_start) starts++;
    if (ack[3]) a3++;
    req[3]          = 1'b1;
    req_data[31:24] = 8'h99;
    step();
    if (tx_start) starts++;
    if (ack[3]) a3++;
    while (grant != 4'd0 && n < 100) begin
      step();
      n++;
      if (tx_start) starts++;
      if (ack[3]) a3++;
    end
    repeat (5) begin
      step();
      if (tx_start) starts++;
      if (ack[3]) a3++;
    end
    checks++;
    if (starts !== 1) begin
      failures++;
      $display("FAIL wd_starts: got %0d want 1", starts);
    end
    checks++;
    if (a3 !== 0) begin
      failures++;
      $display("FAIL wd_ack3: got %0d want 0", a3);
    end
    checks++;
    if (grant !== 4'd0) begin
      failures++;
      $display("FAIL wd_idle: got %0h want 0", grant);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'd0;
    lock     = 4'd0;
    req_data = 32'd0;
    tx_busy  = 1'b0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid_frame();
    test_withdrawal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
